srio_nwr_packer: RTL and testbench
==================================

Name: srio_nwr_packer

Overview:
Downstream of udp2srio_interface in the SRIO clock domain. Converts each length-tagged user frame into one or more SRIO NWRITE request packets on the srio_gen2 IREQ AXI-Stream port in HELLO format. Frames longer than MAX_BYTES are split into consecutive segments, each with its own header, an incremented TID and an advanced target address.

Parameters:
BASE_ADDR, 34'h0_0000_0000, target address of byte 0 of every frame
MAX_BYTES, 256, maximum payload bytes per SRIO packet (multiple of 8, ≤256)
SRC_ID, 16'h0001, source device ID placed in ireq_tuser[31:16]
DEST_ID, 16'h00FF, destination device ID placed in ireq_tuser[15:0]
PRIO, 2'b01, SRIO priority field

Ports:
clk_srio  in  1  SRIO user clock
reset_srio_n  in  1  asynchronous active-low reset
nwr_req_in  in  1  frame request; a frame of nwr_length_in bytes follows on user_*
nwr_length_in  in  16  frame length in bytes, valid with nwr_req_in
user_tdata_in  in  64  frame data, byte 0 in [63:56]
user_tvalid_in  in  1  data valid
user_tkeep_in  in  8  byte enables (informational; size is taken from the length)
user_tlast_in  in  1  last beat of the frame
user_tready_out  out  1  data accept
nwr_ack_out  out  1  one-cycle pulse when a request is accepted
ireq_tdata  out  64  HELLO header or payload
ireq_tvalid  out  1  IREQ valid
ireq_tlast  out  1  last beat of an SRIO packet
ireq_tkeep  out  8  always 8'hFF
ireq_tuser  out  32  {SRC_ID, DEST_ID}
ireq_tready  in  1  IREQ ready from the SRIO core
pkt_done_out  out  1  one-cycle pulse on the final beat of the final segment of a frame
len_err_out  out  1  sticky flag for an early user_tlast_in; cleared only by reset

Behaviour:
- Reset values: all outputs 0 except ireq_tkeep = 8'hFF and ireq_tuser = {SRC_ID, DEST_ID}. TID counter = 0. State = IDLE.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - If nwr_req_in = 1 and nwr_length_in ≠ 0: latch remaining = nwr_length_in and addr = BASE_ADDR, pulse nwr_ack_out, go to HDR.
  - A length-0 request is acked and ignored; no packet is sent.
  - user_tready_out = 0.
- Segment size: seg_bytes = min(remaining, MAX_BYTES); seg_beats = ceil(seg_bytes/8).
- HDR: ireq_tvalid = 1, ireq_tlast = 0. ireq_tdata fields:
  - [63:56] = TID
  - [55:52] = 4'h5 (FTYPE NWRITE)
  - [51:48] = 4'h4 (TTYPE)
  - [47] = 0
  - [46:45] = PRIO
  - [44] = 0
  - [43:36] = seg_bytes − 1, truncated to 8 bits
  - [35:34] = 0
  - [33:0] = addr
- HDR is held stable until ireq_tready = 1; on that handshake go to DATA with beat counter = 0.
- DATA: combinational passthrough:
  - ireq_tdata = user_tdata_in
  - ireq_tvalid = user_tvalid_in
  - user_tready_out = ireq_tready
  - ireq_tlast = (beat == seg_beats − 1) or user_tlast_in
- A beat transfers only when user_tvalid_in & ireq_tready. Each beat increments the beat counter.
- On the tlast beat of a segment:
  - TID += 1, wrapping 8'hFF → 8'h00.
  - remaining −= seg_bytes, clamped at 0.
  - addr += seg_bytes.
  - If remaining > 0 and user_tlast_in = 0: go to HDR for the next segment.
  - Otherwise: pulse pkt_done_out and go to IDLE.
- Early termination: user_tlast_in before the computed final beat closes the current packet on that beat (ireq_tlast = 1), sets len_err_out, and returns to IDLE with no further segments. The header size field is already sent and is not corrected.
- No bubbles are inserted by the block. Header-to-first-data latency is 1 cycle after the header handshake.
- nwr_req_in is ignored outside IDLE.
- Async reset mid-packet returns to IDLE immediately and drives ireq_tvalid = 0. The SRIO core must also be held in reset; no partial-packet recovery is performed.

Test Plan:
- Request length 64, 8 beats, ireq_tready = 1 → header TID 0x00, size 0x3F, addr 0; 8 data beats with tlast on beat 8; pkt_done_out pulses once; total 9 IREQ beats.
- Request length 600 → three packets with sizes 0xFF, 0xFF, 0x57; addresses 0x000, 0x100, 0x200; TIDs 0, 1, 2; data beats 32, 32, 11.
- Length 20, 3 beats → size 0x13; tlast on beat 3; ireq_tkeep = 8'hFF on every beat.
- ireq_tready toggled randomly (50%) during a 256-byte frame → header held stable while stalled; no data lost or duplicated; user_tready_out mirrors ireq_tready in DATA.
- Length 128 with user_tlast_in on beat 5 → packet ends on beat 5 with tlast; len_err_out = 1 and stays 1; FSM returns to IDLE; next request is processed normally.
- 257 consecutive 8-byte frames → TID wraps from 0xFF to 0x00. Assert reset_srio_n low mid-frame → ireq_tvalid = 0 on the next edge; after release, a new frame starts with TID 0.

Source files
------------

// File: rtl/srio_nwr_packer_if.sv
// SRIO IREQ AXI-Stream bus between the NWRITE packer (master) and the srio_gen2 core (slave).
interface srio_nwr_packer_if;
   logic [63:0] tdata;
   logic        tvalid;
   logic        tlast;
   logic [7:0]  tkeep;
   logic [31:0] tuser;
   logic        tready;

   modport master (output tdata, tvalid, tlast, tkeep, tuser, input tready);
   modport slave  (input tdata, tvalid, tlast, tkeep, tuser, output tready);
endinterface

// File: rtl/srio_nwr_packer.sv
// Packs length-tagged user frames into HELLO-format SRIO NWRITE packets,
// splitting frames larger than MAX_BYTES into addressed, TID-tagged segments.
//
// state | meaning
// IDLE  | waiting for a frame request
// HDR   | presenting the HELLO header of the current segment
// DATA  | passing user beats through to IREQ until the segment's last beat
module srio_nwr_packer #(
   parameter logic [33:0] BASE_ADDR = 34'h0_0000_0000,
   parameter int          MAX_BYTES = 256,
   parameter logic [15:0] SRC_ID    = 16'h0001,
   parameter logic [15:0] DEST_ID   = 16'h00FF,
   parameter logic [1:0]  PRIO      = 2'b01
) (
   input  logic              clk_srio,
   input  logic              reset_srio_n,
   input  logic              nwr_req_in,
   input  logic [15:0]       nwr_length_in,
   input  logic [63:0]       user_tdata_in,
   input  logic              user_tvalid_in,
   input  logic [7:0]        user_tkeep_in,
   input  logic              user_tlast_in,
   output logic              user_tready_out,
   output logic              nwr_ack_out,
   output logic              pkt_done_out,
   output logic              len_err_out,
   srio_nwr_packer_if.master ireq
);
   localparam logic [15:0] MAX16 = 16'(MAX_BYTES);

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   state_t      state;
   logic [7:0]  tid;
   logic [15:0] remaining;
   logic [15:0] beat;
   logic [33:0] addr;
   logic        len_err_q;

   logic [15:0] seg_bytes;
   logic [15:0] seg_beats;
   logic [15:0] rem_next;
   logic [7:0]  size_f;
   logic [63:0] hdr;
   logic        last_beat;
   logic        data_fire;
   logic        seg_end;
   logic        frame_end;
   logic        unused_tkeep;

   // Payload size always comes from the request length, never from tkeep.
   assign unused_tkeep = ^user_tkeep_in;

   always_comb begin
      seg_bytes = (remaining > MAX16) ? MAX16 : remaining;
      seg_beats = (seg_bytes + 16'd7) >> 3;
      rem_next  = remaining - seg_bytes;
      size_f    = 8'(seg_bytes - 16'd1);
      hdr       = {tid, 4'h5, 4'h4, 1'b0, PRIO, 1'b0, size_f, 2'b00, addr};
      last_beat = (beat == seg_beats - 16'd1);
      data_fire = (state == DATA) && user_tvalid_in && ireq.tready;
      seg_end   = data_fire && (last_beat || user_tlast_in);
      frame_end = seg_end && ((rem_next == 16'd0) || user_tlast_in);
   end

   always_comb begin
      ireq.tkeep      = 8'hFF;
      ireq.tuser      = {SRC_ID, DEST_ID};
      ireq.tdata      = 64'd0;
      ireq.tvalid     = 1'b0;
      ireq.tlast      = 1'b0;
      user_tready_out = 1'b0;
      case (state)
         HDR: begin
            ireq.tdata  = hdr;
            ireq.tvalid = 1'b1;
         end
         DATA: begin
            ireq.tdata      = user_tdata_in;
            ireq.tvalid     = user_tvalid_in;
            ireq.tlast      = last_beat || user_tlast_in;
            user_tready_out = ireq.tready;
         end
         default: ;
      endcase
   end

   assign nwr_ack_out  = (state == IDLE) && nwr_req_in;
   assign pkt_done_out = frame_end;
   assign len_err_out  = len_err_q;

   always_ff @(posedge clk_srio or negedge reset_srio_n) begin
      if (!reset_srio_n) begin
         state     <= IDLE;
         tid       <= 8'd0;
         remaining <= 16'd0;
         beat      <= 16'd0;
         addr      <= 34'd0;
         len_err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (nwr_req_in && (nwr_length_in != 16'd0)) begin
                  remaining <= nwr_length_in;
                  addr      <= BASE_ADDR;
                  state     <= HDR;
               end
            end
            HDR: begin
               if (ireq.tready) begin
                  beat  <= 16'd0;
                  state <= DATA;
               end
            end
            DATA: begin
               if (data_fire) begin
                  beat <= beat + 16'd1;
                  if (seg_end) begin
                     tid       <= tid + 8'd1;
                     remaining <= rem_next;
                     addr      <= addr + {18'd0, seg_bytes};
                     if (frame_end) begin
                        state <= IDLE;
                        // A frame that ends anywhere but its computed last beat is short.
                        if (user_tlast_in && !(last_beat && (rem_next == 16'd0)))
                           len_err_q <= 1'b1;
                     end else begin
                        state <= HDR;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_srio_nwr_packer.sv
// Scoreboard bench for srio_nwr_packer: directed frames, expected IREQ beats queued
// by the stimulus and popped by an independent monitor.
module tb_srio_nwr_packer;
   logic        clk_srio = 1'b0;
   logic        reset_srio_n = 1'b0;
   logic        nwr_req_in = 1'b0;
   logic [15:0] nwr_length_in = 16'd0;
   logic [63:0] user_tdata_in = 64'd0;
   logic        user_tvalid_in = 1'b0;
   logic [7:0]  user_tkeep_in = 8'hFF;
   logic        user_tlast_in = 1'b0;
   logic        user_tready_out;
   logic        nwr_ack_out;
   logic        pkt_done_out;
   logic        len_err_out;

   srio_nwr_packer_if ireq ();

   srio_nwr_packer dut (
      .clk_srio        (clk_srio),
      .reset_srio_n    (reset_srio_n),
      .nwr_req_in      (nwr_req_in),
      .nwr_length_in   (nwr_length_in),
      .user_tdata_in   (user_tdata_in),
      .user_tvalid_in  (user_tvalid_in),
      .user_tkeep_in   (user_tkeep_in),
      .user_tlast_in   (user_tlast_in),
      .user_tready_out (user_tready_out),
      .nwr_ack_out     (nwr_ack_out),
      .pkt_done_out    (pkt_done_out),
      .len_err_out     (len_err_out),
      .ireq            (ireq)
   );

   initial forever #5 clk_srio = ~clk_srio;

   typedef struct packed {
      logic        hdr;
      logic [63:0] data;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   int    n_total = 0;
   int    n_pass = 0;
   int    done_cnt = 0;
   int    exp_done = 0;
   logic  exp_len_err = 1'b0;
   logic [7:0] m_tid = 8'd0;
   int    fid = 0;
   bit    rand_rdy = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [63:0] word(input int f, input int k);
      logic [15:0] f16;
      logic [15:0] k16;
      f16 = f[15:0];
      k16 = k[15:0];
      return {f16, k16, ~f16, ~k16};
   endfunction

   // Expected IREQ beats for one frame of len bytes of which ubeats user beats are supplied.
   task automatic model_frame(input int len, input int ubeats);
      int rem;
      int consumed;
      logic [33:0] a;
      rem = len;
      consumed = 0;
      a = 34'd0;
      while (rem > 0 && consumed < ubeats) begin
         int sb;
         int nb;
         bit early;
         logic [7:0] szf;
         sb = (rem > 256) ? 256 : rem;
         nb = (sb + 7) / 8;
         szf = 8'(sb - 1);
         early = 1'b0;
         exp_q.push_back('{1'b1, {m_tid, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, szf, 2'b00, a}, 1'b0});
         for (int j = 0; j < nb; j++) begin
            bit l;
            l = (j == nb - 1) || (consumed == ubeats - 1);
            exp_q.push_back('{1'b0, word(fid, consumed), l});
            consumed++;
            if (l) begin
               early = (j != nb - 1);
               break;
            end
         end
         m_tid = m_tid + 8'd1;
         rem = rem - sb;
         a = a + 34'(sb);
         if (consumed == ubeats && (rem > 0 || early)) exp_len_err = 1'b1;
      end
      if (len > 0) exp_done++;
   endtask

   task automatic send_frame(input int len, input int ubeats, input int abort_at);
      int cyc;
      bit acc;
      fid++;
      @(posedge clk_srio); #1;
      nwr_req_in = 1'b1;
      nwr_length_in = len[15:0];
      @(negedge clk_srio);
      chk("nwr_ack", 64'(nwr_ack_out), 64'd1);
      model_frame(len, ubeats);
      @(posedge clk_srio); #1;
      nwr_req_in = 1'b0;
      for (int k = 0; k < ubeats; k++) begin
         user_tvalid_in = 1'b1;
         user_tdata_in = word(fid, k);
         user_tlast_in = (k == ubeats - 1);
         if (k == abort_at) return;
         cyc = 0;
         acc = 1'b0;
         while (!acc && cyc < 2000) begin
            @(negedge clk_srio);
            acc = user_tready_out;
            cyc++;
            if (!acc) begin
               @(posedge clk_srio); #1;
            end
         end
         if (!acc) begin
            chk("user_beat_timeout", 64'(k), 64'(ubeats));
            break;
         end
         @(posedge clk_srio); #1;
      end
      user_tvalid_in = 1'b0;
      user_tlast_in = 1'b0;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 3000) begin
         @(negedge clk_srio);
         cyc++;
      end
      if (exp_q.size() != 0) begin
         chk("ireq_drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      repeat (2) @(negedge clk_srio);
      chk("pkt_done_cnt", 64'(done_cnt), 64'(exp_done));
      chk("len_err", 64'(len_err_out), 64'(exp_len_err));
   endtask

   initial begin
      ireq.tready = 1'b1;
      forever begin
         @(posedge clk_srio); #1;
         ireq.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      beat_t e;
      forever begin
         @(negedge clk_srio);
         if (reset_srio_n && ireq.tvalid) begin
            if (exp_q.size() == 0) begin
               if (ireq.tready) chk("unexpected_beat", ireq.tdata, 64'd0 ^ ~ireq.tdata);
            end else begin
               e = exp_q[0];
               if (e.hdr && !ireq.tready) chk("hdr_hold", ireq.tdata, e.data);
               if (!e.hdr) chk("tready_mirror", 64'(user_tready_out), 64'(ireq.tready));
               if (ireq.tready) begin
                  void'(exp_q.pop_front());
                  chk(e.hdr ? "hdr_data" : "payload", ireq.tdata, e.data);
                  chk("tlast", 64'(ireq.tlast), 64'(e.last));
                  chk("tkeep", 64'(ireq.tkeep), 64'hFF);
                  chk("tuser", 64'(ireq.tuser), 64'h0001_00FF);
               end
            end
         end
         if (reset_srio_n && pkt_done_out) done_cnt++;
      end
   end

   initial begin
      repeat (3) @(posedge clk_srio);
      @(negedge clk_srio);
      chk("rst_tvalid", 64'(ireq.tvalid), 64'd0);
      chk("rst_tlast", 64'(ireq.tlast), 64'd0);
      chk("rst_tdata", ireq.tdata, 64'd0);
      chk("rst_tkeep", 64'(ireq.tkeep), 64'hFF);
      chk("rst_tuser", 64'(ireq.tuser), 64'h0001_00FF);
      chk("rst_user_tready", 64'(user_tready_out), 64'd0);
      chk("rst_done", 64'(pkt_done_out), 64'd0);
      chk("rst_len_err", 64'(len_err_out), 64'd0);
      @(posedge clk_srio); #1;
      reset_srio_n = 1'b1;

      send_frame(64, 8, -1);
      send_frame(600, 75, -1);
      send_frame(20, 3, -1);
      send_frame(0, 0, -1);
      rand_rdy = 1'b1;
      send_frame(256, 32, -1);
      send_frame(600, 75, -1);
      rand_rdy = 1'b0;
      send_frame(128, 5, -1);
      send_frame(40, 5, -1);
      for (int i = 0; i < 257; i++) send_frame(8, 1, -1);

      send_frame(64, 8, 3);
      @(posedge clk_srio); #1;
      reset_srio_n = 1'b0;
      @(negedge clk_srio);
      chk("mid_rst_tvalid", 64'(ireq.tvalid), 64'd0);
      chk("mid_rst_user_tready", 64'(user_tready_out), 64'd0);
      chk("mid_rst_len_err", 64'(len_err_out), 64'd0);
      exp_q.delete();
      m_tid = 8'd0;
      exp_len_err = 1'b0;
      done_cnt = 0;
      exp_done = 0;
      user_tvalid_in = 1'b0;
      user_tlast_in = 1'b0;
      @(posedge clk_srio); #1;
      reset_srio_n = 1'b1;
      send_frame(8, 1, -1);
      send_frame(20, 3, -1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
